// File: rtl/system_muxer.sv
// Program-stream muxer: packs video/audio elementary bytes into PES packets (optional pack header).
// Latency: first header byte valid the cycle after the IDLE decision; bytes stream back-to-back.
// Backpressure: valid/ready; the byte holds while Mux_Ready_I is low, payload stalls while the source FIFO is empty.
//
// Ports: clock/resetn (async active-low); Video_*/Audio_* = FWFT FIFO head byte, fill count, pop strobe;
// Flush_I allows short packets; End_I requests the program end code; Mux_* = valid/ready byte output;
// Done_O = end code fully sent.
// Build option: define SYSTEM_MUXER_PACK_HEADER_EN to emit a 14-byte pack header before every PES header.
module system_muxer #(
    parameter int PAYLOAD_LEN = 2048
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  Video_Data_I,
    input  logic [15:0] Video_Count_I,
    output logic        Video_Read_O,
    input  logic [7:0]  Audio_Data_I,
    input  logic [15:0] Audio_Count_I,
    output logic        Audio_Read_O,
    input  logic        Flush_I,
    input  logic        End_I,
    output logic [7:0]  Mux_Data_O,
    output logic        Mux_Valid_O,
    input  logic        Mux_Ready_I,
    output logic        Done_O
);

    localparam logic [15:0] PLEN = 16'(PAYLOAD_LEN);

    typedef enum logic [2:0] {
        IDLE,
`ifdef SYSTEM_MUXER_PACK_HEADER_EN
        PACK,
`endif
        PES_HDR,
        PAYLOAD,
        END_CODE,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] idx;         // byte index within the current state
    logic [15:0] len;         // payload length latched at selection
    logic        sel_audio;   // stream of the current packet
    logic        last_audio;  // stream served by the previous packet

    logic        video_elig, audio_elig, any_elig, pick_audio;
    logic [15:0] pick_count, sel_count, len_p3;
    logic [7:0]  sel_data;
    logic        fire;

    assign video_elig = (Video_Count_I >= PLEN) || (Flush_I && (Video_Count_I != 16'd0));
    assign audio_elig = (Audio_Count_I >= PLEN) || (Flush_I && (Audio_Count_I != 16'd0));
    assign any_elig   = video_elig || audio_elig;
    // On a tie, serve whichever stream did not go last.
    assign pick_audio = audio_elig && (!video_elig || !last_audio);
    assign pick_count = pick_audio ? Audio_Count_I : Video_Count_I;
    assign sel_count  = sel_audio ? Audio_Count_I : Video_Count_I;
    assign sel_data   = sel_audio ? Audio_Data_I : Video_Data_I;
    // PES_packet_length counts the 3 optional-header bytes after the length field.
    assign len_p3     = len + 16'd3;
    assign fire       = Mux_Valid_O && Mux_Ready_I;

    // State register and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= 16'd0;
            len        <= 16'd0;
            sel_audio  <= 1'b0;
            last_audio <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                idx <= 16'd0;
            end else if (fire) begin
                idx <= idx + 16'd1;
            end
            if ((state == IDLE) && any_elig) begin
                len       <= (pick_count < PLEN) ? pick_count : PLEN;
                sel_audio <= pick_audio;
            end
            if ((state == PAYLOAD) && (state_nxt == IDLE)) begin
                last_audio <= sel_audio;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_elig) begin
`ifdef SYSTEM_MUXER_PACK_HEADER_EN
                    state_nxt = PACK;
`else
                    state_nxt = PES_HDR;
`endif
                end else if (End_I) begin
                    state_nxt = END_CODE;
                end
            end
`ifdef SYSTEM_MUXER_PACK_HEADER_EN
            PACK:     if (fire && (idx == 16'd13)) state_nxt = PES_HDR;
`endif
            PES_HDR:  if (fire && (idx == 16'd8)) state_nxt = PAYLOAD;
            PAYLOAD:  if (fire && (idx == len - 16'd1)) state_nxt = IDLE;
            END_CODE: if (fire && (idx == 16'd3)) state_nxt = DONE;
            DONE:     state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Mux_Data_O   = 8'h00;
        Mux_Valid_O  = 1'b0;
        Video_Read_O = 1'b0;
        Audio_Read_O = 1'b0;
        Done_O       = 1'b0;
        case (state)
`ifdef SYSTEM_MUXER_PACK_HEADER_EN
            PACK: begin
                Mux_Valid_O = 1'b1;
                case (idx[3:0])
                    4'd2:    Mux_Data_O = 8'h01;
                    4'd3:    Mux_Data_O = 8'hBA;
                    4'd4:    Mux_Data_O = 8'h44;
                    4'd6:    Mux_Data_O = 8'h04;
                    4'd8:    Mux_Data_O = 8'h04;
                    4'd9:    Mux_Data_O = 8'h01;
                    4'd10:   Mux_Data_O = 8'h01;
                    4'd11:   Mux_Data_O = 8'h89;
                    4'd12:   Mux_Data_O = 8'hC3;
                    4'd13:   Mux_Data_O = 8'hF8;
                    default: Mux_Data_O = 8'h00;
                endcase
            end
`endif
            PES_HDR: begin
                Mux_Valid_O = 1'b1;
                case (idx[3:0])
                    4'd2:    Mux_Data_O = 8'h01;
                    4'd3:    Mux_Data_O = sel_audio ? 8'hC0 : 8'hE0;
                    4'd4:    Mux_Data_O = len_p3[15:8];
                    4'd5:    Mux_Data_O = len_p3[7:0];
                    4'd6:    Mux_Data_O = 8'h80;
                    default: Mux_Data_O = 8'h00;
                endcase
            end
            PAYLOAD: begin
                Mux_Data_O   = sel_data;
                Mux_Valid_O  = (sel_count != 16'd0);
                Video_Read_O = !sel_audio && Mux_Valid_O && Mux_Ready_I;
                Audio_Read_O = sel_audio && Mux_Valid_O && Mux_Ready_I;
            end
            END_CODE: begin
                Mux_Valid_O = 1'b1;
                case (idx[3:0])
                    4'd2:    Mux_Data_O = 8'h01;
                    4'd3:    Mux_Data_O = 8'hB9;
                    default: Mux_Data_O = 8'h00;
                endcase
            end
            DONE:    Done_O = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_system_muxer.sv
// Directed bench for system_muxer with PAYLOAD_LEN=4 and FWFT FIFO models on both inputs.
// Latency: n/a (bench).
// Backpressure: Mux_Ready_I driven fixed or random per test.
module tb_system_muxer;

    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  Video_Data_I = 8'h00;
    logic [15:0] Video_Count_I = 16'd0;
    logic        Video_Read_O;
    logic [7:0]  Audio_Data_I = 8'h00;
    logic [15:0] Audio_Count_I = 16'd0;
    logic        Audio_Read_O;
    logic        Flush_I = 1'b0;
    logic        End_I = 1'b0;
    logic [7:0]  Mux_Data_O;
    logic        Mux_Valid_O;
    logic        Mux_Ready_I = 1'b1;
    logic        Done_O;

    system_muxer #(.PAYLOAD_LEN(4)) dut (
        .clock(clock), .resetn(resetn),
        .Video_Data_I(Video_Data_I), .Video_Count_I(Video_Count_I), .Video_Read_O(Video_Read_O),
        .Audio_Data_I(Audio_Data_I), .Audio_Count_I(Audio_Count_I), .Audio_Read_O(Audio_Read_O),
        .Flush_I(Flush_I), .End_I(End_I),
        .Mux_Data_O(Mux_Data_O), .Mux_Valid_O(Mux_Valid_O), .Mux_Ready_I(Mux_Ready_I),
        .Done_O(Done_O)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass = 0;

    bq_t        vq, aq, out_q, exp_q;
    logic       vgate = 1'b0;
    logic       rnd_ready = 1'b0;
    int         cyc = 0;
    int         vreads, areads, stab_err, rd_err, first_fire, last_fire;
    logic       prev_stall;
    logic [7:0] prev_data;

`ifdef SYSTEM_MUXER_PACK_HEADER_EN
    localparam int HDR_BYTES = 23;
`else
    localparam int HDR_BYTES = 9;
`endif

    task automatic drive();
        Video_Data_I  = (vq.size() > 0) ? vq[0] : 8'h00;
        Video_Count_I = vgate ? 16'd0 : 16'(vq.size());
        Audio_Data_I  = (aq.size() > 0) ? aq[0] : 8'h00;
        Audio_Count_I = 16'(aq.size());
    endtask

    // One clock: sample outputs at the falling edge, apply FIFO pops just after the rising edge.
    task automatic tick();
        logic pv, pa;
        @(negedge clock);
        cyc++;
        if (prev_stall && Mux_Valid_O && (Mux_Data_O !== prev_data)) stab_err++;
        prev_stall = Mux_Valid_O && !Mux_Ready_I;
        prev_data  = Mux_Data_O;
        if (Mux_Valid_O && Mux_Ready_I) begin
            out_q.push_back(Mux_Data_O);
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        pv = Video_Read_O;
        pa = Audio_Read_O;
        if ((pv || pa) && !(Mux_Valid_O && Mux_Ready_I)) rd_err++;
        if (pv && pa) rd_err++;
        @(posedge clock);
        #1;
        if (pv) begin
            vreads++;
            if (vq.size() > 0) void'(vq.pop_front());
        end
        if (pa) begin
            areads++;
            if (aq.size() > 0) void'(aq.pop_front());
        end
        if (rnd_ready) Mux_Ready_I = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic run_until(input int n, input int budget, output bit timed_out);
        for (int i = 0; i < budget && out_q.size() < n; i++) tick();
        timed_out = (out_q.size() < n);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        vq.delete(); aq.delete(); out_q.delete(); exp_q.delete();
        vgate = 1'b0; Flush_I = 1'b0; End_I = 1'b0; Mux_Ready_I = 1'b1; rnd_ready = 1'b0;
        vreads = 0; areads = 0; stab_err = 0; rd_err = 0; first_fire = -1; last_fire = -1;
        prev_stall = 1'b0; prev_data = 8'h00;
        drive();
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic add_pes(input logic [7:0] id, input bq_t pl);
        logic [15:0] l3;
`ifdef SYSTEM_MUXER_PACK_HEADER_EN
        logic [7:0] pk [14] = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h44, 8'h00, 8'h04,
                                8'h00, 8'h04, 8'h01, 8'h01, 8'h89, 8'hC3, 8'hF8};
        for (int i = 0; i < 14; i++) exp_q.push_back(pk[i]);
`endif
        l3 = 16'(pl.size() + 3);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(id);    exp_q.push_back(l3[15:8]); exp_q.push_back(l3[7:0]);
        exp_q.push_back(8'h80); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        foreach (pl[i]) exp_q.push_back(pl[i]);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        Mux_Ready_I = 1'b1;
        #3;
        n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL reset_valid: got %b want 0", Mux_Valid_O); else n_pass++;
        n_checks++; if (Mux_Data_O !== 8'h00) $display("FAIL reset_data: got %h want 00", Mux_Data_O); else n_pass++;
        n_checks++; if ({Video_Read_O, Audio_Read_O} !== 2'b00) $display("FAIL reset_reads: got %b want 00", {Video_Read_O, Audio_Read_O}); else n_pass++;
        n_checks++; if (Done_O !== 1'b0) $display("FAIL reset_done: got %b want 0", Done_O); else n_pass++;
    endtask

    task automatic test_single_video();
        bit to;
        int start;
        bq_t pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_reset();
        vq = pl;
        drive();
        add_pes(8'hE0, pl);
        start = cyc;
        run_until(exp_q.size(), 200, to);
        n_checks++; if (to) $display("FAIL video_timeout: got %0d bytes want %0d", out_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) $display("FAIL video_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (vreads !== 4) $display("FAIL video_reads: got %0d want 4", vreads); else n_pass++;
        n_checks++; if (areads !== 0) $display("FAIL video_audio_reads: got %0d want 0", areads); else n_pass++;
        n_checks++; if (first_fire - start !== 2) $display("FAIL video_latency: got %0d want 2", first_fire - start); else n_pass++;
        n_checks++; if (last_fire - first_fire !== HDR_BYTES + 3) $display("FAIL video_back_to_back: got %0d want %0d", last_fire - first_fire, HDR_BYTES + 3); else n_pass++;
        n_checks++; if (rd_err !== 0) $display("FAIL video_read_strobe: got %0d errors want 0", rd_err); else n_pass++;
        repeat (3) tick();
        n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL video_idle_valid: got %b want 0", Mux_Valid_O); else n_pass++;
    endtask

    task automatic test_alternate();
        bit to;
        bq_t v1 = '{8'h10, 8'h11, 8'h12, 8'h13};
        bq_t v2 = '{8'h14, 8'h15, 8'h16, 8'h17};
        bq_t a1 = '{8'h20, 8'h21, 8'h22, 8'h23};
        do_reset();
        vq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        aq = a1;
        drive();
        add_pes(8'hE0, v1);
        add_pes(8'hC0, a1);
        add_pes(8'hE0, v2);
        run_until(exp_q.size(), 300, to);
        n_checks++; if (to) $display("FAIL alt_timeout: got %0d bytes want %0d", out_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) $display("FAIL alt_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if ({vreads, areads} !== {32'd8, 32'd4}) $display("FAIL alt_reads: got v%0d a%0d want v8 a4", vreads, areads); else n_pass++;
    endtask

    task automatic test_flush();
        bit to;
        bq_t pl = '{8'h55, 8'h66};
        do_reset();
        aq = pl;
        Flush_I = 1'b1;
        drive();
        add_pes(8'hC0, pl);
        run_until(exp_q.size(), 200, to);
        n_checks++; if (to) $display("FAIL flush_timeout: got %0d bytes want %0d", out_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) $display("FAIL flush_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
        end
        repeat (3) tick();
        n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL flush_idle_valid: got %b want 0", Mux_Valid_O); else n_pass++;
        n_checks++; if ({vreads, areads} !== {32'd0, 32'd2}) $display("FAIL flush_reads: got v%0d a%0d want v0 a2", vreads, areads); else n_pass++;
        Flush_I = 1'b0;
    endtask

    task automatic test_stall();
        bit gated = 1'b0;
        logic [7:0] held;
        bq_t pl = '{8'h31, 8'h32, 8'h33, 8'h34};
        do_reset();
        rnd_ready = 1'b1;
        vq = pl;
        drive();
        add_pes(8'hE0, pl);
        for (int i = 0; i < 800 && out_q.size() < exp_q.size(); i++) begin
            tick();
            if (!gated && vreads == 2) begin
                gated = 1'b1;
                vgate = 1'b1;
                drive();
                #1;
                n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL stall_empty_valid: got %b want 0", Mux_Valid_O); else n_pass++;
                held = Mux_Data_O;
                repeat (4) tick();
                n_checks++; if (Mux_Data_O !== held) $display("FAIL stall_empty_data: got %h want %h", Mux_Data_O, held); else n_pass++;
                n_checks++; if (vreads !== 2) $display("FAIL stall_empty_reads: got %0d want 2", vreads); else n_pass++;
                vgate = 1'b0;
                drive();
            end
        end
        n_checks++; if (out_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d bytes want %0d", out_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) $display("FAIL stall_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (stab_err !== 0) $display("FAIL stall_stability: got %0d changes want 0", stab_err); else n_pass++;
        n_checks++; if (rd_err !== 0) $display("FAIL stall_read_strobe: got %0d errors want 0", rd_err); else n_pass++;
        n_checks++; if (vreads !== 4) $display("FAIL stall_reads: got %0d want 4", vreads); else n_pass++;
        rnd_ready = 1'b0;
        Mux_Ready_I = 1'b1;
    endtask

    task automatic test_end_code();
        bit to;
        do_reset();
        End_I = 1'b1;
        drive();
        exp_q = '{8'h00, 8'h00, 8'h01, 8'hB9};
        run_until(4, 100, to);
        n_checks++; if (to) $display("FAIL end_timeout: got %0d bytes want 4", out_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) $display("FAIL end_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
        end
        repeat (6) tick();
        n_checks++; if (Done_O !== 1'b1) $display("FAIL end_done: got %b want 1", Done_O); else n_pass++;
        n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL end_valid: got %b want 0", Mux_Valid_O); else n_pass++;
        n_checks++; if (out_q.size() !== 4) $display("FAIL end_extra: got %0d bytes want 4", out_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        vq = '{8'h41, 8'h42, 8'h43, 8'h44};
        drive();
        for (int i = 0; i < 100 && vreads < 2; i++) tick();
        n_checks++; if (Mux_Valid_O !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", Mux_Valid_O); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (Mux_Valid_O !== 1'b0) $display("FAIL midrst_valid: got %b want 0", Mux_Valid_O); else n_pass++;
        n_checks++; if (Mux_Data_O !== 8'h00) $display("FAIL midrst_data: got %h want 00", Mux_Data_O); else n_pass++;
        n_checks++; if ({Video_Read_O, Audio_Read_O} !== 2'b00) $display("FAIL midrst_reads: got %b want 00", {Video_Read_O, Audio_Read_O}); else n_pass++;
        n_checks++; if (Done_O !== 1'b0) $display("FAIL midrst_done: got %b want 0", Done_O); else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_video();
        test_alternate();
        test_flush();
        test_stall();
        test_end_code();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/system_muxer.md
SYSTEM_MUXER -- requirements
Module: system_muxer

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 2048, maximum payload bytes per PES packet; legal range 1..65532.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Video_Data_I  input  8  head byte of video elementary FIFO (first-word fall-through).
REQ-005 SHALL have port Video_Count_I  input  16  bytes available in video FIFO.
REQ-006 SHALL have port Video_Read_O  output  1  video FIFO pop strobe.
REQ-007 SHALL have port Audio_Data_I  input  8  head byte of audio elementary FIFO (first-word fall-through).
REQ-008 SHALL have port Audio_Count_I  input  16  bytes available in audio FIFO.
REQ-009 SHALL have port Audio_Read_O  output  1  audio FIFO pop strobe.
REQ-010 SHALL have port Flush_I  input  1  level; allows short packets below PAYLOAD_LEN.
REQ-011 SHALL have port End_I  input  1  level; request program end code.
REQ-012 SHALL have port Mux_Data_O  output  8  program stream byte.
REQ-013 SHALL have port Mux_Valid_O  output  1  Mux_Data_O valid.
REQ-014 SHALL have port Mux_Ready_I  input  1  downstream accepts byte.
REQ-015 SHALL have port Done_O  output  1  end code fully sent.

Function
REQ-016 SHALL transfer a byte only on a clock edge with Mux_Valid_O & Mux_Ready_I; Mux_Data_O SHALL stay stable while Mux_Valid_O is high and Mux_Ready_I is low.
REQ-017 SHALL use states IDLE, PACK, PES_HDR, PAYLOAD, END_CODE and DONE, with a byte-index counter cleared on every state entry.
REQ-018 IDLE: a stream is eligible when Count >= PAYLOAD_LEN, or when Flush_I=1 and Count != 0.
REQ-019 IDLE: if both streams are eligible, SHALL select the stream not served last; a single eligible stream SHALL be selected directly.
REQ-020 IDLE: on selection, SHALL latch len = min(Count, PAYLOAD_LEN) and stream id (E0 video, C0 audio), then go to PACK if enabled, else PES_HDR.
REQ-021 IDLE: if End_I=1 and neither stream is eligible, SHALL go to END_CODE; eligible data takes priority over End_I.
REQ-022 PES_HDR: SHALL emit 9 bytes: 00 00 01 id, (len+3)[15:8], (len+3)[7:0], 80, 00, 00, then go to PAYLOAD.
REQ-023 PAYLOAD: Mux_Data_O SHALL be the selected stream's Data_I.
REQ-024 PAYLOAD: Mux_Valid_O SHALL be high only while the selected stream's Count != 0.
REQ-025 PAYLOAD: the selected stream's Read_O SHALL equal Mux_Valid_O & Mux_Ready_I; the other stream's Read_O SHALL stay 0.
REQ-026 PAYLOAD: after len accepted bytes, SHALL record the last-served stream and return to IDLE.
REQ-027 END_CODE: SHALL emit 00 00 01 B9, then go to DONE.
REQ-028 DONE: SHALL hold Done_O=1 and Mux_Valid_O=0 until reset.
REQ-029 Mux_Valid_O SHALL be 0 in IDLE; the first header byte SHALL be valid on the cycle after the IDLE decision.
REQ-030 Header bytes SHALL be output back-to-back when Mux_Ready_I stays 1, with no bubbles between states.
REQ-031 Count_I changes after latch SHALL NOT alter len; Flush_I deasserting mid-packet SHALL NOT truncate the packet.

Reset
REQ-032 Asynchronous reset SHALL force IDLE, clear the index and len, and set last-served to audio so video wins the first tie.
REQ-033 Asynchronous reset SHALL drive Mux_Valid_O=0, Mux_Data_O=00, both Read_O=0 and Done_O=0, including mid-packet.

Configuration
REQ-034 With macro SYSTEM_MUXER_PACK_HEADER_EN defined, SHALL emit a 14-byte pack header before each PES header: 00 00 01 BA 44 00 04 00 04 01 01 89 C3 F8.
REQ-035 Without SYSTEM_MUXER_PACK_HEADER_EN, SHALL omit the PACK state; output is a bare PES sequence.

Verification
REQ-036 PAYLOAD_LEN=4, macro off, Video_Count=4 holding AA BB CC DD, Ready=1 -> bytes 00 00 01 E0 00 07 80 00 00 AA BB CC DD, exactly 4 Video_Read_O pulses.
REQ-037 Both counts >= PAYLOAD_LEN after reset -> packet order E0, C0, E0 (alternating).
REQ-038 Audio_Count=2, Flush_I=1, PAYLOAD_LEN=4 -> header 00 00 01 C0 00 05 80 00 00, then 2 payload bytes, then IDLE.
REQ-039 Mux_Ready_I toggled randomly; Video_Count dropping to 0 mid-payload -> Mux_Valid_O low, Mux_Data_O stable while stalled, no lost or duplicated bytes.
REQ-040 Macro on, End_I=1 with empty FIFOs -> 00 00 01 B9, then Done_O=1 held; a separate run applies resetn low mid-payload -> all outputs return to reset values immediately.
